mpq_host: RTL and testbench

//  Host-side initiator for the max-priority-queue engine: buffers an input data set and a

---
 rtl/mpq_host.sv | 205 ++++++++++++++++++++
 tb/tb_mpq_host.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpq_host.sv
// rtl/mpq_host.sv - host initiator that buffers data and commands, replays them to a max-priority-queue engine, and captures its write-back
module mpq_host #(
  parameter int MAX_N     = 255,
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       cq_valid,
  input  logic [2:0] cq_cmd,
  input  logic [7:0] cq_index,
  input  logic [7:0] cq_value,
  output logic       cq_ready,
  input  logic       start,
  output logic       mpq_rst,
  output logic       data_valid,
  output logic [7:0] data,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [7:0] index,
  output logic [7:0] value,
  input  logic       busy,
  input  logic       RAM_valid,
  input  logic [7:0] RAM_A,
  input  logic [7:0] RAM_D,
  input  logic       done,
  input  logic [7:0] res_addr,
  output logic [7:0] res_data,
  output logic [7:0] res_count,
  output logic       job_done,
  output logic       err
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MRST, S_STREAM, S_DRAIN, S_ISSUE, S_GAP, S_WAITB, S_COLLECT, S_ERR
  } state_t;

  state_t        state;
  logic [7:0]    dcount;
  logic [7:0]    ptr;
  logic [TW-1:0] timer;
  logic          timeout_hit;

  logic [7:0]    dbuf [MAX_N];
  logic [7:0]    rbuf [256];

  // Command FIFO: {cmd, index, value} per entry
  logic [18:0]   fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fcount;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [18:0]   head;

  assign full        = (fcount == (AW+1)'(CMD_DEPTH));
  assign empty       = (fcount == '0);
  assign cq_ready    = !full && (state != S_ERR);
  assign push        = cq_valid && cq_ready;
  assign pop         = (state == S_ISSUE) && !busy && !empty;
  assign head        = fifo_mem[rd_ptr];
  assign in_ready    = (state == S_IDLE) && (dcount < 8'(MAX_N));
  assign res_data    = rbuf[res_addr];
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  // FIFO pointer and occupancy bookkeeping; a full FIFO refuses a push even if it pops that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fcount <= fcount + 1'b1;
      else if (pop && !push) fcount <= fcount - 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cq_cmd, cq_index, cq_value};
  end

  // Data buffer fill in IDLE; a word arriving alongside start is dropped
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_ready && !start) dbuf[dcount] <= in_data;
  end

  // Result buffer capture of the engine write-back stream
  always_ff @(posedge clk) begin
    if (!rst && state == S_COLLECT && RAM_valid) rbuf[RAM_A] <= RAM_D;
  end

  // Job sequencer with registered engine-side outputs; timer restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dcount     <= '0;
      ptr        <= '0;
      timer      <= '0;
      mpq_rst    <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      cmd_valid  <= 1'b0;
      cmd        <= '0;
      index      <= '0;
      value      <= '0;
      res_count  <= '0;
      job_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      mpq_rst   <= 1'b0;
      cmd_valid <= 1'b0;
      job_done  <= 1'b0;
      timer     <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (dcount == '0) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state     <= S_MRST;
              mpq_rst   <= 1'b1;
              res_count <= '0;
            end
          end else if (in_valid && in_ready) begin
            dcount <= dcount + 8'd1;
          end
        end
        S_MRST: begin
          data_valid <= 1'b1;
          data       <= dbuf[0];
          ptr        <= 8'd1;
          state      <= S_STREAM;
        end
        S_STREAM: begin
          if (ptr == dcount) begin
            data_valid <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            data <= dbuf[ptr];
            ptr  <= ptr + 8'd1;
          end
        end
        S_DRAIN: state <= S_ISSUE;
        S_ISSUE: begin
          if (pop) begin
            cmd_valid <= 1'b1;
            cmd       <= head[18:16];
            index     <= head[15:8];
            value     <= head[7:0];
            state     <= (head[18:16] == 3'd4) ? S_COLLECT : S_GAP;
          end else if (busy) begin
            if (timeout_hit) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_GAP: state <= S_WAITB;
        S_WAITB: begin
          if (!busy) begin
            state <= S_ISSUE;
          end else if (timeout_hit) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COLLECT: begin
          if (RAM_valid) res_count <= RAM_A + 8'd1;
          if (done) begin
            job_done <= 1'b1;
            dcount   <= '0;
            state    <= S_IDLE;
          end else if (timeout_hit) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_ERR: begin
          data_valid <= 1'b0;
          err        <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpq_host.sv
// tb/tb_mpq_host.sv - directed self-checking bench for mpq_host
module tb_mpq_host;
  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       cq_valid = 1'b0;
  logic [2:0] cq_cmd = '0;
  logic [7:0] cq_index = '0;
  logic [7:0] cq_value = '0;
  logic       cq_ready;
  logic       start = 1'b0;
  logic       mpq_rst;
  logic       data_valid;
  logic [7:0] data;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [7:0] index;
  logic [7:0] value;
  logic       busy = 1'b0;
  logic       RAM_valid = 1'b0;
  logic [7:0] RAM_A = '0;
  logic [7:0] RAM_D = '0;
  logic       done = 1'b0;
  logic [7:0] res_addr = '0;
  logic [7:0] res_data;
  logic [7:0] res_count;
  logic       job_done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  int cv_count = 0;

  mpq_host #(.MAX_N(255), .CMD_DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cq_valid(cq_valid), .cq_cmd(cq_cmd), .cq_index(cq_index), .cq_value(cq_value),
    .cq_ready(cq_ready), .start(start), .mpq_rst(mpq_rst),
    .data_valid(data_valid), .data(data),
    .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value), .busy(busy),
    .RAM_valid(RAM_valid), .RAM_A(RAM_A), .RAM_D(RAM_D), .done(done),
    .res_addr(res_addr), .res_data(res_data), .res_count(res_count),
    .job_done(job_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc_now <= cyc_now + 1;
    if (cmd_valid) cv_count <= cv_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
    cq_valid = 1'b1;
    cq_cmd   = c;
    cq_index = i;
    cq_value = v;
    tick();
    cq_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cmd();
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_valid) check("wait_cmd_bound", 32'd0, 32'd1);
  endtask

  task automatic ram_word(input logic [7:0] a, input logic [7:0] d);
    RAM_valid = 1'b1;
    RAM_A     = a;
    RAM_D     = d;
    tick();
    RAM_valid = 1'b0;
  endtask

  task automatic finish_job();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("job_done_pulse", job_done, 1);
    tick();
    check("job_done_clear", job_done, 0);
  endtask

  task automatic check_res(input logic [7:0] a, input logic [7:0] exp);
    res_addr = a;
    #1;
    check("res_data", res_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c1;
    int c2;
    int n;
    tick();
    do_reset();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_cq_ready", cq_ready, 1);
    check("rst_err", err, 0);
    check("rst_res_count", res_count, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_mpq_rst", mpq_rst, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_job_done", job_done, 0);

    // Job 1: data 5,2,9, commands build + write-out
    load(8'd5); load(8'd2); load(8'd9);
    push(3'd0, 8'd0, 8'd0);
    push(3'd4, 8'd0, 8'd0);
    pulse_start();
    check("j1_mpq_rst", mpq_rst, 1);
    check("j1_dv_in_mrst", data_valid, 0);
    tick();
    check("j1_mpq_rst_1cyc", mpq_rst, 0);
    check("j1_dv0", data_valid, 1);
    check("j1_d0", data, 8'd5);
    tick();
    check("j1_dv1", data_valid, 1);
    check("j1_d1", data, 8'd2);
    tick();
    check("j1_dv2", data_valid, 1);
    check("j1_d2", data, 8'd9);
    tick();
    check("j1_dv_end", data_valid, 0);
    wait_cmd();
    check("j1_cmd0", cmd, 3'd0);
    busy = 1'b1;
    tick();
    check("j1_cmd_valid_1cyc", cmd_valid, 0);
    tick();
    tick();
    busy = 1'b0;
    wait_cmd();
    check("j1_cmd1", cmd, 3'd4);
    ram_word(8'd0, 8'd9);
    ram_word(8'd1, 8'd2);
    ram_word(8'd2, 8'd5);
    finish_job();
    check("j1_res_count", res_count, 8'd3);
    check_res(8'd0, 8'd9);
    check_res(8'd1, 8'd2);
    check_res(8'd2, 8'd5);
    check("j1_in_ready", in_ready, 1);
    check("j1_cmd_pulses", cv_count, 2);

    // Job 2: data 3,1, insert 7 then write-out
    load(8'd3); load(8'd1);
    push(3'd3, 8'd0, 8'd7);
    push(3'd4, 8'd0, 8'd0);
    pulse_start();
    wait_cmd();
    c1 = cyc_now;
    check("j2_cmd0", cmd, 3'd3);
    check("j2_index0", index, 8'd0);
    check("j2_value0", value, 8'd7);
    busy = 1'b1;
    tick();
    tick();
    busy = 1'b0;
    wait_cmd();
    c2 = cyc_now;
    check("j2_cmd1", cmd, 3'd4);
    check("j2_gap_ge3", (c2 - c1) >= 3, 1);
    ram_word(8'd0, 8'd7);
    ram_word(8'd1, 8'd1);
    ram_word(8'd2, 8'd3);
    finish_job();
    check("j2_res_count", res_count, 8'd3);
    check_res(8'd0, 8'd7);
    check_res(8'd1, 8'd1);
    check_res(8'd2, 8'd3);
    check("j2_cmd_pulses", cv_count, 4);

    // Start with no data -> sticky error
    pulse_start();
    check("e_err", err, 1);
    check("e_no_mpq_rst", mpq_rst, 0);
    check("e_in_ready", in_ready, 0);
    check("e_cq_ready", cq_ready, 0);
    tick();
    check("e_err_sticky", err, 1);
    do_reset();
    check("e_err_cleared", err, 0);

    // FIFO full: 16 accepted, 17th held until a pop
    load(8'd4);
    for (int i = 0; i < 16; i++) push(3'd0, 8'(i), 8'd0);
    check("f_full_ready", cq_ready, 0);
    cq_valid = 1'b1;
    cq_cmd   = 3'd4;
    cq_index = 8'd99;
    cq_value = 8'd0;
    pulse_start();
    wait_cmd();
    busy = 1'b1;
    check("f_ready_after_pop", cq_ready, 1);
    check("f_head_cmd", cmd, 3'd0);
    check("f_head_index", index, 8'd0);
    tick();
    cq_valid = 1'b0;
    check("f_full_again", cq_ready, 0);
    do_reset();
    busy = 1'b0;

    // Timeout with busy stuck high after a command
    load(8'd1);
    push(3'd0, 8'd1, 8'd1);
    pulse_start();
    wait_cmd();
    busy = 1'b1;
    n = 0;
    while (!err && n < TIMEOUT + 50) begin
      tick();
      n++;
    end
    check("t_err", err, 1);
    check("t_latency", (n >= TIMEOUT) && (n <= TIMEOUT + 2), 1);
    check("t_dv", data_valid, 0);
    check("t_cmd_valid", cmd_valid, 0);
    check("t_cq_ready", cq_ready, 0);
    check("t_in_ready", in_ready, 0);
    busy = 1'b0;
    do_reset();

    // Reset mid-STREAM clears data, FIFO and outputs
    load(8'd1); load(8'd2); load(8'd3);
    push(3'd0, 8'd0, 8'd0);
    pulse_start();
    tick();
    check("r_dv_before", data_valid, 1);
    rst = 1'b1;
    tick();
    check("r_dv", data_valid, 0);
    check("r_in_ready", in_ready, 1);
    check("r_cq_ready", cq_ready, 1);
    check("r_mpq_rst", mpq_rst, 0);
    rst = 1'b0;
    load(8'h55);
    push(3'd4, 8'd0, 8'd0);
    pulse_start();
    check("r_mpq_rst_new", mpq_rst, 1);
    tick();
    check("r_dv_new", data_valid, 1);
    check("r_d_new", data, 8'h55);
    tick();
    check("r_dv_one_word", data_valid, 0);
    wait_cmd();
    check("r_fifo_was_empty", cmd, 3'd4);
    ram_word(8'd0, 8'h55);
    finish_job();
    check("r_res_count", res_count, 8'd1);
    check_res(8'd0, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
